// File: rtl/csc_col_sched_pkg.sv
// Shared definitions for the CSC column scheduler: index and pointer widths,
// value-select encodings and the scheduler FSM state type.
// Used by: csc_col_sched_if, csc_col_sched, tb_csc_col_sched.
package csc_pkg;

  localparam int MAT_RANK = 256;
  // Row/column index width.
  localparam int IDX_W    = $clog2(MAT_RANK);
  // Pointer width must hold the total nnz of a full-rank tridiagonal: 3*N-2.
  localparam int PTR_W    = $clog2(3 * MAT_RANK - 1);

  // Value select: which diagonal the entry's value comes from.
  localparam logic [1:0] SEL_A0 = 2'd0;  // sub-diagonal
  localparam logic [1:0] SEL_S  = 2'd1;  // diagonal
  localparam logic [1:0] SEL_A1 = 2'd2;  // super-diagonal

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COLPTR = 2'd1,
    ENT    = 2'd2,
    FINPTR = 2'd3
  } state_t;

endpackage

// File: rtl/csc_col_sched_if.sv
// Scheduler output bus: column-pointer strobe (no backpressure) and the
// entry-descriptor valid/ready stream.
// master: scheduler side (drives pointers/entries, receives ent_rdy).
// slave : consumer side (value-storage/datapath stage).
interface csc_col_sched_if
  import csc_pkg::*;
#(
  parameter int P_IDX_W = IDX_W,
  parameter int P_PTR_W = PTR_W
);
  logic               colptr_vld;
  logic [P_IDX_W:0]   colptr_idx;
  logic [P_PTR_W-1:0] colptr_val;
  logic               ent_vld;
  logic               ent_rdy;
  logic [P_IDX_W-1:0] ent_row;
  logic [P_IDX_W-1:0] ent_col;
  logic [1:0]         ent_sel;
  logic               ent_last;

  modport master (
    output colptr_vld, colptr_idx, colptr_val,
    output ent_vld, ent_row, ent_col, ent_sel, ent_last,
    input  ent_rdy
  );

  modport slave (
    input  colptr_vld, colptr_idx, colptr_val,
    input  ent_vld, ent_row, ent_col, ent_sel, ent_last,
    output ent_rdy
  );
endinterface

// File: rtl/csc_col_sched.sv
// Column scheduler for CSC generation of a tridiagonal matrix (a1 super,
// s diag, a0 sub). Emits one column pointer per column plus a final pointer,
// and the column's non-zero descriptors in ascending row order.
// Ports: clk, rst_n (async active-low), start/abort/cfg_last control in,
// busy/done status out, stall_cnt statistic, bus (csc_col_sched_if.master).
// Optional: CSC_SCHED_STAT_EN builds the saturating ent stall counter;
// otherwise stall_cnt is tied to 0.
module csc_col_sched
  import csc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] cfg_last,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt,
  csc_col_sched_if.master  bus
);

  localparam logic [IDX_W-1:0] ROW_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   IDX_ONE = (IDX_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_col;
  logic [PTR_W-1:0]   r_ptr;
  logic [1:0]         r_off;     // row offset in column: row = col-1+off
  logic               r_busy;
  logic               r_done;
  logic               r_cp_vld;
  logic [IDX_W:0]     r_cp_idx;
  logic [PTR_W-1:0]   r_cp_val;
  logic               r_ent_vld;
  logic [IDX_W-1:0]   r_ent_row;
  logic [1:0]         r_ent_sel;
  logic               r_ent_last;

  logic               w_xfer;
  logic               w_col_last;
  logic               w_more;
  logic [PTR_W-1:0]   w_ptr_inc;

  assign w_xfer     = r_ent_vld & bus.ent_rdy;
  assign w_col_last = (r_col == r_last);
  // Another entry follows the current one in this column: after the
  // super-diagonal there is always the diagonal; after the diagonal there is
  // a sub-diagonal entry unless this is the last column.
  assign w_more     = (r_off == 2'd0) | ((r_off == 2'd1) & ~w_col_last);
  assign w_ptr_inc  = r_ptr + PTR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= '0;
      r_col      <= '0;
      r_ptr      <= '0;
      r_off      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cp_vld   <= 1'b0;
      r_cp_idx   <= '0;
      r_cp_val   <= '0;
      r_ent_vld  <= 1'b0;
      r_ent_row  <= '0;
      r_ent_sel  <= '0;
      r_ent_last <= 1'b0;
    end else if (abort) begin
      // Abort beats start and any transfer in the same cycle.
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cp_vld   <= 1'b0;
      r_ent_vld  <= 1'b0;
      r_ent_last <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done    <= 1'b0;
          r_cp_vld  <= 1'b0;
          r_ent_vld <= 1'b0;
          if (start) begin
            r_last   <= cfg_last;
            r_col    <= '0;
            r_ptr    <= '0;
            r_busy   <= 1'b1;
            r_cp_vld <= 1'b1;
            r_cp_idx <= '0;
            r_cp_val <= '0;
            r_state  <= COLPTR;
          end
        end
        COLPTR: begin
          // Pointer strobe ends; load the column's first entry.
          r_cp_vld  <= 1'b0;
          r_ent_vld <= 1'b1;
          r_state   <= ENT;
          if (r_col == '0) begin
            r_off      <= 2'd1;
            r_ent_row  <= r_col;
            r_ent_sel  <= SEL_S;
            r_ent_last <= w_col_last;
          end else begin
            r_off      <= 2'd0;
            r_ent_row  <= r_col - ROW_ONE;
            r_ent_sel  <= SEL_A1;
            r_ent_last <= 1'b0;
          end
        end
        ENT: begin
          if (w_xfer) begin
            r_ptr <= w_ptr_inc;
            if (w_more) begin
              // Next row down; select walks A1 -> S -> A0 as offset rises.
              r_off      <= r_off + 2'd1;
              r_ent_row  <= r_ent_row + ROW_ONE;
              r_ent_sel  <= r_ent_sel - 2'd1;
              r_ent_last <= (r_off == 2'd0) & w_col_last;
            end else begin
              r_ent_vld  <= 1'b0;
              r_ent_last <= 1'b0;
              r_cp_vld   <= 1'b1;
              r_cp_val   <= w_ptr_inc;
              if (w_col_last) begin
                r_cp_idx <= {1'b0, r_last} + IDX_ONE;
                r_done   <= 1'b1;
                r_state  <= FINPTR;
              end else begin
                r_col    <= r_col + ROW_ONE;
                r_cp_idx <= {1'b0, r_col} + IDX_ONE;
                r_state  <= COLPTR;
              end
            end
          end
        end
        FINPTR: begin
          r_cp_vld <= 1'b0;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign bus.colptr_vld = r_cp_vld;
  assign bus.colptr_idx = r_cp_idx;
  assign bus.colptr_val = r_cp_val;
  assign bus.ent_vld    = r_ent_vld;
  assign bus.ent_row    = r_ent_row;
  assign bus.ent_col    = r_col;
  assign bus.ent_sel    = r_ent_sel;
  assign bus.ent_last   = r_ent_last;

`ifdef CSC_SCHED_STAT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if ((r_state == IDLE) && start && !abort) begin
      r_stall <= '0;
    end else if (r_ent_vld && !bus.ent_rdy && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/csc_col_sched.md
Name: csc_col_sched

Overview:
Column scheduler that sequences CSC generation of the tridiagonal system matrix used by csc_stor (a1 super-diagonal, s diagonal, a0 sub-diagonal).
- Walks columns 0..N-1 and emits one column-pointer word at the start of each column, plus a final pointer after the last column.
- For each column, emits the non-zero entry descriptors (row, col, value select) in ascending row order over a valid/ready handshake.
- Sits between the top-level control FSM and the value-storage/datapath stage.

Parameters:
MAT_RANK, 256, maximum matrix rank supported
IDX_W, 8, row/column index width (clog2(MAT_RANK))
PTR_W, 10, column-pointer width; must hold 3*MAT_RANK-2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; ignored while busy
abort  in  1  synchronous abort; returns to IDLE
cfg_last  in  IDX_W  rank-1 (N-1), sampled on accepted start
busy  out  1  high from the cycle after start until the done cycle inclusive
done  out  1  one-cycle pulse coincident with final pointer emission
colptr_vld  out  1  column-pointer strobe (no backpressure)
colptr_idx  out  IDX_W+1  pointer index 0..N
colptr_val  out  PTR_W  cumulative nnz before column colptr_idx
ent_vld  out  1  entry valid
ent_rdy  in  1  downstream ready
ent_row  out  IDX_W  row index
ent_col  out  IDX_W  column index
ent_sel  out  2  value select: 0=a0 (sub), 1=s (diag), 2=a1 (super)
ent_last  out  1  last entry of the whole matrix
stall_cnt  out  16  stall statistic (see Optional Feature)

Behaviour:
Reset: all outputs 0, state IDLE, counters 0.

FSM states and transitions:
- IDLE: start=1 latches cfg_last, clears col=0 and ptr=0, then goes to COLPTR.
- COLPTR: one cycle; colptr_vld=1, colptr_idx=col, colptr_val=ptr. Then goes to ENT.
- ENT: entries for column j, in order:
  - row j-1, sel=2, only if j>0
  - row j, sel=1
  - row j+1, sel=0, only if j<cfg_last
  - ent_vld is held with stable payload until ent_rdy; transfer = ent_vld&ent_rdy.
  - ptr increments per transfer.
  - After the column's last transfer: goes to COLPTR with col+1 if col<cfg_last, else FINPTR.
- FINPTR: one cycle; colptr_vld=1, colptr_idx=N, colptr_val=3N-2, done=1. Then goes to IDLE.

Control rules:
- Latency: start accepted in cycle 0 puts the first colptr_vld in cycle 1. The first ent_vld appears in cycle 2.
- No bubble between consecutive entries of a column when ent_rdy=1.
- ent_last=1 only on entry (cfg_last, cfg_last, sel=1).
- cfg_last=0 (N=1): single entry (0,0,s) with ent_last=1; pointers 0,1.
- start during busy is ignored. abort has priority over start and over any transfer in the same cycle.
- abort from any state: next cycle IDLE with all strobes 0. No done is issued; the partial output is discarded by the consumer.
- rst_n asserted mid-run: immediate return to reset values.

Widths:
- colptr_idx is IDX_W+1 so that N=MAT_RANK is representable.
- ptr never overflows PTR_W by parameter constraint.

Optional Feature:
CSC_SCHED_STAT_EN
- Defined: stall_cnt counts cycles with ent_vld&!ent_rdy, saturating at 16'hFFFF. It is cleared on accepted start and held after done.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package csc_pkg holds:
  - ent_sel encodings SEL_A0=0, SEL_S=1, SEL_A1=2
  - FSM state enum (IDLE, COLPTR, ENT, FINPTR)
  - width helper constants for IDX_W/PTR_W derivation
- No sub-module is needed: a single FSM plus a row-offset counter (0..2) is sufficient.

Test Plan:
- cfg_last=3, ent_rdy=1:
  - pointers 0,2,5,8,10 at colptr_idx 0..4
  - 10 entries in order (0,0,1)(1,0,0)(0,1,2)(1,1,1)(2,1,0)(1,2,2)(2,2,1)(3,2,0)(2,3,2)(3,3,1)
  - done in cycle 15 after start
- Same config, ent_rdy toggling 1/0 each cycle: identical entry sequence and payload held while stalled; with CSC_SCHED_STAT_EN, stall_cnt=number of stalled cycles.
- cfg_last=0: pointers 0,1; single entry (0,0,1) with ent_last=1; done in cycle 3.
- cfg_last=255, ent_rdy=1: 766 entries; final colptr_idx=256, colptr_val=766; no wrap of idx or ptr.
- abort during column 2 of a cfg_last=3 run: next cycle busy=0 and ent_vld=0, no done. A following start rebuilds from pointer 0.
- start pulsed while busy: no restart, sequence unchanged. rst_n low mid-run: all outputs 0 immediately.
